// File: rtl/sqrtn_pkg.sv
// Shared types and constant helpers for the parametrised floating-point square-root unit.
package sqrtn_pkg;

    typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;

    typedef enum logic [2:0] {CL_NAN, CL_NEG, CL_PINF, CL_ZERO, CL_FIN} class_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] pinf(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
        return r;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, only the top mantissa bit set.
    function automatic logic [63:0] qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = pinf(exp_w, man_w);
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sqrtn_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module sqrtn_lzc #(
    parameter  int WIDTH = 10,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count
);

    logic found;

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (data[i]) found = 1'b1;
                else         count = count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sqrtn.sv
// Iterative IEEE-754 square root with valid/ready handshakes, RNE rounding and an inexact flag.
module sqrtn
    import sqrtn_pkg::*;
#(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] OUT_DATA,
    output logic         IS_NAN,
    output logic         IS_PINF,
    output logic         IS_ZERO,
    output logic         IS_INEXACT
);

    localparam int N   = MAN_W + 2;               // root bits: integer, fraction, guard
    localparam int RW  = MAN_W + 4;
    localparam int LZW = $clog2(MAN_W + 1);
    localparam int EW  = EXP_W + LZW + 2;
    localparam int CW  = $clog2(N + 1);

    localparam logic [63:0]          QNAN64 = qnan(EXP_W, MAN_W);
    localparam logic [63:0]          PINF64 = pinf(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN_W = QNAN64[W-1:0];
    localparam logic [W-1:0]         PINF_W = PINF64[W-1:0];
    localparam logic signed [EW-1:0] BIAS_S = EW'(bias(EXP_W));

    state_t               state, state_nxt;
    class_t               cls;
    logic [W-2:0]         op;
    logic [2*N-1:0]       rad;
    logic [RW-1:0]        rem;
    logic [N-1:0]         root;
    logic [CW-1:0]        cnt;
    logic [EXP_W-1:0]     res_exp;
    logic [W-1:0]         out_data_q;
    logic                 nan_q, pinf_q, zero_q, inexact_q;

    logic                 in_sign;
    logic [EXP_W-1:0]     in_exp, op_exp;
    logic [MAN_W-1:0]     in_man, op_man;
    logic [LZW-1:0]       lzc;
    logic signed [EW-1:0] e_unb, e_even;
    logic [MAN_W:0]       sig;
    logic [N-1:0]         rad_init;
    logic [EXP_W-1:0]     res_exp_d;
    logic [RW-1:0]        trial, divisor, diff;
    logic                 fits;
    logic                 guard, sticky, round_up;
    logic [MAN_W+1:0]     sum;
    logic [EXP_W-1:0]     rnd_exp;

    assign in_sign = IN_DATA[W-1];
    assign in_exp  = IN_DATA[W-2 -: EXP_W];
    assign in_man  = IN_DATA[MAN_W-1:0];
    assign op_exp  = op[W-2 -: EXP_W];
    assign op_man  = op[MAN_W-1:0];

    always_comb begin
        cls = CL_FIN;
        if (&in_exp)                        cls = (|in_man) ? CL_NAN : (in_sign ? CL_NEG : CL_PINF);
        else if (in_exp == '0 && in_man == '0) cls = CL_ZERO;
        else if (in_sign)                   cls = CL_NEG;
    end

    sqrtn_lzc #(.WIDTH(MAN_W)) u_lzc (
        .data  (op_man),
        .count (lzc)
    );

    // A denormal's leading one moves to the hidden position with a shift of lzc+1.
    always_comb begin
        if (op_exp == '0) begin
            e_unb = -BIAS_S - $signed(EW'(lzc));
            sig   = {1'b0, op_man} << (lzc + LZW'(1));
        end else begin
            e_unb = $signed(EW'(op_exp)) - BIAS_S;
            sig   = {1'b1, op_man};
        end
        if (e_unb[0]) begin
            rad_init = {sig, 1'b0};
            e_even   = e_unb - EW'(1);
        end else begin
            rad_init = {1'b0, sig};
            e_even   = e_unb;
        end
        res_exp_d = EXP_W'((e_even >>> 1) + BIAS_S);
    end

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        trial   = {rem[RW-3:0], rad[2*N-1 -: 2]};
        divisor = {root, 2'b01};
        fits    = (trial >= divisor);
        diff    = trial - divisor;
    end

    always_comb begin
        guard    = root[0];
        sticky   = |rem;
        round_up = guard & (sticky | root[1]);
        sum      = {1'b0, root[N-1:1]} + (MAN_W + 2)'(round_up);
        rnd_exp  = res_exp + EXP_W'(sum[MAN_W+1]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (IN_VALID) state_nxt = (cls == CL_FIN) ? NORM : DONE;
            NORM:    state_nxt = ITER;
            ITER:    if (cnt == CW'(N - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op         <= '0;
            rad        <= '0;
            rem        <= '0;
            root       <= '0;
            cnt        <= '0;
            res_exp    <= '0;
            out_data_q <= '0;
            nan_q      <= 1'b0;
            pinf_q     <= 1'b0;
            zero_q     <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (IN_VALID) begin
                    op <= IN_DATA[W-2:0];
                    if (cls != CL_FIN) begin
                        nan_q     <= (cls == CL_NAN) || (cls == CL_NEG);
                        pinf_q    <= (cls == CL_PINF);
                        zero_q    <= (cls == CL_ZERO);
                        inexact_q <= 1'b0;
                        if (cls == CL_PINF)      out_data_q <= PINF_W;
                        else if (cls == CL_ZERO) out_data_q <= IN_DATA;
                        else                     out_data_q <= QNAN_W;
                    end
                end
                NORM: begin
                    rad     <= {rad_init, {N{1'b0}}};
                    rem     <= '0;
                    root    <= '0;
                    cnt     <= '0;
                    res_exp <= res_exp_d;
                end
                ITER: begin
                    rad  <= rad << 2;
                    root <= {root[N-2:0], fits};
                    rem  <= fits ? diff : trial;
                    cnt  <= cnt + CW'(1);
                end
                ROUND: begin
                    out_data_q <= {1'b0, rnd_exp, sum[MAN_W-1:0]};
                    nan_q      <= 1'b0;
                    pinf_q     <= 1'b0;
                    zero_q     <= 1'b0;
                    inexact_q  <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

    assign IN_READY   = (state == IDLE);
    assign OUT_VALID  = (state == DONE);
    assign OUT_DATA   = out_data_q;
    assign IS_NAN     = nan_q;
    assign IS_PINF    = pinf_q;
    assign IS_ZERO    = zero_q;
    assign IS_INEXACT = inexact_q;

endmodule

// File: tb/tb_sqrtn.sv
// Self-checking bench: FP16 and FP32 instances against an integer-sqrt reference with RNE.
module tb_sqrtn;

    logic        clk = 1'b0;
    logic        rst_n;
    bit          wide;
    logic        in_valid, out_ready;
    logic [63:0] in_data;

    logic        h_in_ready, h_out_valid, h_nan, h_pinf, h_zero, h_inexact;
    logic [15:0] h_out_data;
    logic        s_in_ready, s_out_valid, s_nan, s_pinf, s_zero, s_inexact;
    logic [31:0] s_out_data;

    logic        cur_in_ready, cur_out_valid;
    logic [63:0] cur_data;
    logic [3:0]  cur_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrtn #(.EXP_W(5), .MAN_W(10)) u_h (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid & ~wide), .IN_READY(h_in_ready), .IN_DATA(in_data[15:0]),
        .OUT_VALID(h_out_valid), .OUT_READY(out_ready & ~wide), .OUT_DATA(h_out_data),
        .IS_NAN(h_nan), .IS_PINF(h_pinf), .IS_ZERO(h_zero), .IS_INEXACT(h_inexact)
    );

    sqrtn #(.EXP_W(8), .MAN_W(23)) u_s (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid & wide), .IN_READY(s_in_ready), .IN_DATA(in_data[31:0]),
        .OUT_VALID(s_out_valid), .OUT_READY(out_ready & wide), .OUT_DATA(s_out_data),
        .IS_NAN(s_nan), .IS_PINF(s_pinf), .IS_ZERO(s_zero), .IS_INEXACT(s_inexact)
    );

    assign cur_in_ready  = wide ? s_in_ready  : h_in_ready;
    assign cur_out_valid = wide ? s_out_valid : h_out_valid;
    assign cur_data      = wide ? {32'd0, s_out_data} : {48'd0, h_out_data};
    assign cur_flags     = wide ? {s_nan, s_pinf, s_zero, s_inexact} : {h_nan, h_pinf, h_zero, h_inexact};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer square root of the scaled significand, then RNE to MAN_W bits.
    // Flags are returned as {nan, pinf, zero, inexact}.
    function automatic void model(input logic [63:0] x, input int ew, input int mw,
                                  output logic [63:0] r, output logic [3:0] fl);
        longint unsigned man, ex, emax, mant, nrad, lo, hi, mid, kept;
        int  e, k, p, ue, bias_v;
        bit  sgn, guard, sticky;
        emax   = (64'd1 << ew) - 1;
        man    = x & ((64'd1 << mw) - 1);
        ex     = (x >> mw) & emax;
        sgn    = x[ew + mw];
        bias_v = (1 << (ew - 1)) - 1;
        r  = '0;
        fl = '0;
        if ((ex == emax && man != 0) || (sgn && !(ex == 0 && man == 0))) begin
            r  = (emax << mw) | (64'd1 << (mw - 1));
            fl = 4'b1000;
        end else if (ex == 0 && man == 0) begin
            r  = x;
            fl = 4'b0010;
        end else if (ex == emax) begin
            r  = emax << mw;
            fl = 4'b0100;
        end else begin
            if (ex == 0) begin
                mant = man;
                e    = 1 - bias_v - mw;
            end else begin
                mant = man | (64'd1 << mw);
                e    = int'(ex) - bias_v - mw;
            end
            if (e % 2 != 0) begin
                mant = mant << 1;
                e    = e - 1;
            end
            p = mw + 3;
            k = 0;
            nrad = mant;
            while (nrad < (64'd1 << (2 * p))) begin
                nrad = nrad << 2;
                k++;
            end
            lo = 0;
            hi = 64'd1 << (p + 1);
            while (lo < hi) begin
                mid = (lo + hi + 1) >> 1;
                if (mid * mid <= nrad) lo = mid;
                else                   hi = mid - 1;
            end
            ue     = p + e / 2 - k;
            guard  = lo[2];
            sticky = (lo[1:0] != 2'b00) || (lo * lo != nrad);
            kept   = lo >> 3;
            if (guard && (sticky || kept[0])) kept = kept + 1;
            if ((kept >> (mw + 1)) != 0) begin
                kept = kept >> 1;
                ue   = ue + 1;
            end
            r  = (64'(ue + bias_v) << mw) | (kept & ((64'd1 << mw) - 1));
            fl = {3'b000, guard | sticky};
        end
    endfunction

    // Latency is counted in edges after the accept edge; specials are valid in the very next cycle.
    task automatic run_op(input logic [63:0] x, input int hold, input bit poke_en, input logic [63:0] poke,
                          output logic [63:0] got, output logic [3:0] got_fl);
        int          ew, mw, lat, wait_n;
        logic [63:0] r;
        logic [3:0]  fl;
        bit          special;
        ew = wide ? 8 : 5;
        mw = wide ? 23 : 10;
        model(x, ew, mw, r, fl);
        special = fl[3] | fl[2] | fl[1];
        @(negedge clk);
        wait_n = 0;
        while (!cur_in_ready && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_wait", wait_n < 100, 1);
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!cur_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, special ? 0 : mw + 4);
        check("result", cur_data, r);
        check("flags", cur_flags, fl);
        got    = cur_data;
        got_fl = cur_flags;
        if (poke_en) begin
            in_valid = 1'b1;
            in_data  = poke;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", cur_out_valid, 1);
            check("hold_data", cur_data, r);
            check("hold_flags", cur_flags, fl);
            check("hold_busy", cur_in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("released", {cur_out_valid, cur_in_ready}, 2'b01);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        logic [3:0]  gfl;
        logic [63:0] x;

        rst_n = 1'b0; wide = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #1;
        check("rst_h", {h_in_ready, h_out_valid, h_nan, h_pinf, h_zero, h_inexact, h_out_data}, {6'b100000, 16'h0});
        check("rst_s", {s_in_ready, s_out_valid, s_nan, s_pinf, s_zero, s_inexact, s_out_data}, {6'b100000, 32'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(64'h4400, 0, 1'b0, 0, got, gfl);
        check("tp_4400", {got, gfl}, {64'h4000, 4'b0000});
        run_op(64'h4000, 1, 1'b0, 0, got, gfl);
        check("tp_4000", {got, gfl}, {64'h3DA8, 4'b0001});
        run_op(64'h0001, 0, 1'b0, 0, got, gfl);
        check("tp_0001", {got, gfl}, {64'h0C00, 4'b0000});
        run_op(64'h000A, 0, 1'b0, 0, got, gfl);
        run_op(64'hFC00, 0, 1'b0, 0, got, gfl);
        check("tp_fc00", {got, gfl}, {64'h7E00, 4'b1000});
        run_op(64'h7D30, 0, 1'b0, 0, got, gfl);
        check("tp_7d30", {got, gfl}, {64'h7E00, 4'b1000});
        run_op(64'h8541, 0, 1'b0, 0, got, gfl);
        check("tp_8541", {got, gfl}, {64'h7E00, 4'b1000});
        run_op(64'h7C00, 0, 1'b0, 0, got, gfl);
        check("tp_7c00", {got, gfl}, {64'h7C00, 4'b0100});
        run_op(64'h8000, 0, 1'b0, 0, got, gfl);
        check("tp_8000", {got, gfl}, {64'h8000, 4'b0010});

        // Back-pressure with an operand offered while the result is still held.
        run_op(64'h6066, 5, 1'b1, 64'h3604, got, gfl);
        repeat (3) @(negedge clk);
        check("poke_ignored", {h_in_ready, h_out_valid}, 2'b10);

        // Reset six cycles into an operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h7777;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", h_in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {h_in_ready, h_out_valid, h_nan, h_pinf, h_zero, h_inexact, h_out_data}, {6'b100000, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst", {h_in_ready, h_out_valid}, 2'b10);
        run_op(64'h4400, 0, 1'b0, 0, got, gfl);
        check("tp_after_rst", got, 64'h4000);

        for (int i = 0; i < 150; i++) begin
            x = 64'($urandom & 32'hFFFF);
            if (i % 3 != 0) x[15] = 1'b0;
            run_op(x, int'($urandom_range(0, 2)), 1'b0, 0, got, gfl);
        end

        wide = 1'b1;
        run_op(64'h40800000, 0, 1'b0, 0, got, gfl);
        check("tp_s_4", {got, gfl}, {64'h40000000, 4'b0000});
        run_op(64'hBF800000, 0, 1'b0, 0, got, gfl);
        check("tp_s_neg1", {got, gfl}, {64'h7FC00000, 4'b1000});
        for (int i = 0; i < 30; i++) begin
            x = 64'($urandom);
            if (i % 4 != 0) x[31] = 1'b0;
            run_op(x, int'($urandom_range(0, 1)), 1'b0, 0, got, gfl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
